// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the FSM state encoding, the iteration count
// and small helpers that classify an operation.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;  // operand / result width
  localparam int MD_STEPS = 32;  // one shift-add or shift-subtract step per cycle
  localparam int MD_CNT_W = 6;   // iteration counter width

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // Signed variants work on magnitudes and correct the sign in FIX.
  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_negate.sv
// md_negate: conditional two's-complement negate.
// Ports:
//   en     - when high, result = -value; otherwise result = value
//   value  - input word
//   result - (optionally) negated word
// Used to form operand magnitudes and to apply the signed-result corrections.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = en ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide for the HI/LO path.
// One operation at a time: IDLE -> CALC (32 steps) -> FIX (sign correction)
// -> DONE (result strobe). Signed operations run on magnitudes.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start, op, a, b       - request (sampled only in IDLE), operation, operands
//   busy                  - high from the cycle after start through DONE
//   done                  - one-cycle result strobe
//   div_by_zero           - divide with b == 0 (valid with done, held after)
//   hi_result, lo_result  - registered results, held until the next DONE
//   hi_write, lo_write    - HI/LO write enables, equal to done
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int ACC_W = 2 * WIDTH;

  md_state_e             state_q, state_d;
  md_op_e                op_q;
  logic [MD_CNT_W-1:0]   count_q;
  logic                  sign_a_q, sign_b_q, b_zero_q;
  logic [WIDTH-1:0]      mag_a_q, mag_b_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   low half is the quotient being shifted in.
  logic [ACC_W-1:0]      acc_q;
  logic [WIDTH-1:0]      rem_q;

  // Operand magnitudes, formed combinationally from the request.
  md_op_e           op_req;
  logic             signed_req;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_req     = md_op_e'(op);
  assign signed_req = md_is_signed(op_req);

  md_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en(signed_req & a[WIDTH-1]), .value(a), .result(mag_a)
  );
  md_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en(signed_req & b[WIDTH-1]), .value(b), .result(mag_b)
  );

  // One iteration of each algorithm.
  logic [WIDTH:0] mul_sum;    // upper half plus (optional) multiplicand, with carry
  logic [WIDTH:0] div_shift;  // 33-bit partial remainder after shifting in a dividend bit
  logic [WIDTH:0] div_diff;   // trial subtraction; MSB set means it borrowed

  assign mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};

  // Sign corrections applied in FIX.
  logic             sign_diff;
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign sign_diff = sign_a_q ^ sign_b_q;

  md_negate #(.WIDTH(ACC_W)) u_neg_prod (
    .en((op_q == MD_MULT) & sign_diff), .value(acc_q), .result(prod_fix)
  );
  md_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .en((op_q == MD_DIV) & sign_diff), .value(acc_q[WIDTH-1:0]), .result(quo_fix)
  );
  // Remainder follows the dividend's sign.
  md_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en((op_q == MD_DIV) & sign_a_q), .value(rem_q), .result(rem_fix)
  );

  // Next state and FSM outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (count_q == MD_CNT_W'(MD_STEPS - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        state_d  = ST_IDLE;
        done     = 1'b1;
        hi_write = 1'b1;
        lo_write = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and architecturally visible results.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      hi_result   <= '0;
      lo_result   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) count_q <= '0;
      else if (state_q == ST_CALC)     count_q <= count_q + 1'b1;

      // Results are captured on the FIX -> DONE edge so they are valid with done.
      if (state_q == ST_FIX) begin
        if (md_is_div(op_q)) begin
          hi_result   <= rem_fix;
          lo_result   <= b_zero_q ? '1 : quo_fix;
          div_by_zero <= b_zero_q;
        end else begin
          hi_result   <= prod_fix[ACC_W-1:WIDTH];
          lo_result   <= prod_fix[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // Datapath working registers.
  // NOTE: these carry no reset; they are always loaded in IDLE before use, and
  // nothing visible depends on them until the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_q     <= op_req;
          sign_a_q <= signed_req & a[WIDTH-1];
          sign_b_q <= signed_req & b[WIDTH-1];
          b_zero_q <= (b == '0);
          mag_a_q  <= mag_a;
          mag_b_q  <= mag_b;
          rem_q    <= '0;
          acc_q    <= md_is_div(op_req) ? {{WIDTH{1'b0}}, mag_a}
                                        : {{WIDTH{1'b0}}, mag_b};
        end
      end
      ST_CALC: begin
        if (md_is_div(op_q)) begin
          // Restoring step: keep the difference only if it did not borrow.
          rem_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_q <= {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          // Shift-add step: consume one multiplier bit from the bottom.
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// A cycle-level reference model (plain arithmetic plus a phase count since the
// accepted start) is compared against the DUT on every falling edge; directed
// operations additionally check hand-computed literal results and latency.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero, hi_write, lo_write;
  logic [31:0] hi_result, lo_result;

  int tests  = 0;
  int failed = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_result(hi_result), .lo_result(lo_result),
    .hi_write(hi_write), .lo_write(lo_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sx, sy, sq, sr;
    logic        [63:0] ux, uy, up, uq, ur;
    z = 1'b0;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: begin sq = sx * sy; h = sq[63:32]; l = sq[31:0]; end
      2'b01: begin up = ux * uy; h = up[63:32]; l = up[31:0]; end
      2'b10: begin
        if (y == 0) begin z = 1'b1; h = x; l = 32'hFFFF_FFFF; end
        else begin sq = sx / sy; sr = sx % sy; h = sr[31:0]; l = sq[31:0]; end
      end
      default: begin
        if (y == 0) begin z = 1'b1; h = x; l = 32'hFFFF_FFFF; end
        else begin uq = ux / uy; ur = ux % uy; h = ur[31:0]; l = uq[31:0]; end
      end
    endcase
  endfunction

  int          m_phase = 0;  // 0 idle, else cycle number since the accepted start
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dbz = 1'b0, p_dbz = 1'b0;
  bit          cmp_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        model_calc(op, a, b, p_hi, p_lo, p_dbz);
        m_phase = 1;
      end
    end else if (m_phase == 33) begin
      m_phase = 34;
      m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
    end else if (m_phase == 34) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc busy",        busy,        (m_phase != 0));
      check("cyc done",        done,        (m_phase == 34));
      check("cyc hi_write",    hi_write,    (m_phase == 34));
      check("cyc lo_write",    lo_write,    (m_phase == 34));
      check("cyc hi_result",   hi_result,   m_hi);
      check("cyc lo_result",   lo_result,   m_lo);
      check("cyc div_by_zero", div_by_zero, m_dbz);
    end
  end

  // ---------------- directed operations ----------------
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, 34);
    check({name, " hi"},      hi_result, exp_hi);
    check({name, " lo"},      lo_result, exp_lo);
    check({name, " dbz"},     div_by_zero, exp_dbz);
    @(negedge clk);
    check({name, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int dcount;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi",   hi_result, 32'h0);
    check("reset lo",   lo_result, 32'h0);
    check("reset dbz",  div_by_zero, 1'b0);
    cmp_en = 1'b1;

    run_op("multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3*5",   2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu by 0",   2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("div 7/-2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("multu 3*5",   2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0);
    run_op("divu 100/7",  2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("mult min^2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div -7/0",    2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("mult 12*-1",  2'b00, 32'h0000_000C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

    // Start while busy: only the first operation completes.
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b01; a = 32'd7; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("busy start ignored dones", dcount, 1);
    check("busy start ignored lo",    lo_result, 32'h0000_000F);

    // Reset in the middle of a divide: abort, clear results, no done.
    @(negedge clk);
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset busy", busy, 1'b0);
    check("mid reset hi",   hi_result, 32'h0);
    check("mid reset lo",   lo_result, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid reset no done", dcount, 0);

    // First operation after reset behaves normally.
    run_op("post reset divu", 2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // Start held high: the next operation is accepted right after DONE.
    @(negedge clk);
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    dcount = 0;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("held start dones", dcount, 2);
    check("held start lo",    lo_result, 32'd42);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port a  input  32  multiplicand or dividend (rs).
REQ-007 SHALL have port b  input  32  multiplier or divisor (rt).
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port div_by_zero  output  1  divide with b==0, valid when done is high.
REQ-011 SHALL have ports hi_result, lo_result  output  32 each  registered results for the HI/LO register file.
REQ-012 SHALL have ports hi_write, lo_write  output  1 each  write enables to HI/LO; equal to done.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 In IDLE with start=1, SHALL latch op, |a|, |b| (magnitudes for signed ops) and the sign flags, clear the 6-bit iteration counter, and go to CALC.
REQ-015 In CALC, MULT/MULTU SHALL perform one radix-2 shift-add step per cycle on a 64-bit accumulator, for 32 cycles.
REQ-016 In CALC, DIV/DIVU SHALL perform one restoring shift-subtract step per cycle (33-bit remainder, 32-bit quotient), for 32 cycles.
REQ-017 FIX (1 cycle) SHALL apply signed-op corrections:
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the signs differ; negate the remainder if a<0.
REQ-018 In DONE (1 cycle), SHALL assert done, hi_write and lo_write, and drive the result:
- Multiply: hi_result = product[63:32], lo_result = product[31:0].
- Divide: hi_result = remainder, lo_result = quotient.
REQ-019 Latency: done SHALL be high in exactly the 34th cycle after the edge that samples start.
REQ-020 busy SHALL be high from the cycle after start through the DONE cycle inclusive.
REQ-021 start asserted while busy SHALL be ignored, with no queuing.
REQ-022 Signed division SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-023 Division by zero SHALL keep normal latency, set div_by_zero=1, and produce hi_result=a, lo_result=32'hFFFFFFFF.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce lo_result=32'h80000000, hi_result=0, div_by_zero=0.
REQ-025 hi_result, lo_result and div_by_zero SHALL hold their values until the next DONE.
REQ-026 done SHALL be asserted for one cycle only, never back-to-back.
REQ-027 A new start SHALL be accepted earliest in the cycle after DONE.

Reset
REQ-028 reset SHALL force, asynchronously:
- FSM to IDLE, counter to 0.
- busy, done, hi_write, lo_write and div_by_zero to 0.
- hi_result and lo_result to 32'h0.
REQ-029 reset mid-operation SHALL abort the operation with no done or write pulse; the first start after reset release SHALL behave normally.

Structure
REQ-030 The op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the FSM state encoding SHALL live in the shared CPU package.
REQ-031 The unit SHALL be a single module; the 32-bit conditional negate may be a sub-module named md_negate, instantiated for the operand and result corrections.

Verification
REQ-032 MULTU a=FFFFFFFF, b=FFFFFFFF -> at cycle 34: hi=FFFFFFFE, lo=00000001, done=hi_write=lo_write=1 for one cycle.
REQ-033 MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1.
REQ-034 DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-035 DIVU a=00000064, b=0 -> at cycle 34: div_by_zero=1, hi=00000064, lo=FFFFFFFF.
REQ-036 Reset mid-operation and start-while-busy:
- DIVU start, reset at cycle 10 -> busy=0, no done, hi=lo=0.
- MULTU start, second start at cycle 5 -> only one done, with the first operation's result.
